// File: rtl/datapath_unit_if.sv
// Control-word and result bundle between the control unit (master) and the datapath (slave).
interface datapath_unit_if;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned RF_AW  = 4;
   localparam int unsigned MEM_AW = 8;

   logic [MEM_AW-1:0] D_addr;
   logic              D_Wr;
   logic              RF_s;
   logic              RF_W_en;
   logic [RF_AW-1:0]  RF_W_addr;
   logic [RF_AW-1:0]  RF_Ra_addr;
   logic [RF_AW-1:0]  RF_Rb_addr;
   logic [2:0]        ALU_s0;
   logic [DATA_W-1:0] Ra_data;
   logic [DATA_W-1:0] Rb_data;
   logic [DATA_W-1:0] ALU_out;
   logic [DATA_W-1:0] mem_q;
   logic              zero;

   modport master (
      output D_addr, D_Wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0,
      input  Ra_data, Rb_data, ALU_out, mem_q, zero
   );

   modport slave (
      input  D_addr, D_Wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0,
      output Ra_data, Rb_data, ALU_out, mem_q, zero
   );
endinterface

// File: rtl/datapath_unit.sv
// Execution datapath: 16x16 register file, 256x16 data memory, write-back mux and 8-function ALU.
module datapath_unit (
   input  logic            clk,
   input  logic            reset,
   datapath_unit_if.slave  bus
);
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned RF_DEPTH  = 16;
   localparam int unsigned MEM_DEPTH = 256;

   logic [DATA_W-1:0] rf [RF_DEPTH];
   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic [DATA_W-1:0] mem_q_r;
   logic [DATA_W-1:0] alu_c;
   logic [DATA_W-1:0] wb_data;

   // Register file: async clear, one synchronous write port, no read bypass
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(RF_DEPTH); i++) rf[i] <= '0;
      end else if (bus.RF_W_en) begin
         rf[bus.RF_W_addr] <= wb_data;
      end
   end

   assign bus.Ra_data = rf[bus.RF_Ra_addr];
   assign bus.Rb_data = rf[bus.RF_Rb_addr];

   // Data memory array kept reset-free so it maps onto block RAM; writes blocked during reset
   always_ff @(posedge clk) begin
      if (reset && bus.D_Wr) mem[bus.D_addr] <= bus.Ra_data;
   end

   // Registered read port returns pre-write contents on a same-address collision
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) mem_q_r <= '0;
      else        mem_q_r <= mem[bus.D_addr];
   end

   assign bus.mem_q = mem_q_r;

   always_comb begin
      alu_c = '0;
      case (bus.ALU_s0)
         3'b000: alu_c = '0;
         3'b001: alu_c = bus.Ra_data + bus.Rb_data;
         3'b010: alu_c = bus.Ra_data - bus.Rb_data;
         3'b011: alu_c = bus.Ra_data;
         3'b100: alu_c = bus.Ra_data ^ bus.Rb_data;
         3'b101: alu_c = bus.Ra_data | bus.Rb_data;
         3'b110: alu_c = bus.Ra_data & bus.Rb_data;
         3'b111: alu_c = bus.Ra_data + DATA_W'(1);
      endcase
   end

   assign wb_data     = bus.RF_s ? mem_q_r : alu_c;
   assign bus.ALU_out = alu_c;
   assign bus.zero    = (alu_c == '0);
endmodule

// File: tb/tb_datapath_unit.sv
// Directed self-checking bench for datapath_unit with hand-computed expected values.
module tb_datapath_unit;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   datapath_unit_if bus ();

   datapath_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.D_addr     = 8'h00;
      bus.D_Wr       = 1'b0;
      bus.RF_s       = 1'b0;
      bus.RF_W_en    = 1'b0;
      bus.RF_W_addr  = 4'd0;
      bus.RF_Ra_addr = 4'd0;
      bus.RF_Rb_addr = 4'd0;
      bus.ALU_s0     = 3'b000;
   endtask

   // Build a constant in register r: clear, then double (r+r) and increment (r+1) MSB first
   task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
      bus.D_Wr       = 1'b0;
      bus.RF_s       = 1'b0;
      bus.RF_Ra_addr = r;
      bus.RF_Rb_addr = r;
      bus.RF_W_addr  = r;
      bus.RF_W_en    = 1'b1;
      bus.ALU_s0     = 3'b000;
      cyc();
      for (int b = 15; b >= 0; b--) begin
         bus.ALU_s0 = 3'b001;
         cyc();
         if (v[b]) begin
            bus.ALU_s0 = 3'b111;
            cyc();
         end
      end
      bus.RF_W_en = 1'b0;
      bus.ALU_s0  = 3'b000;
   endtask

   logic [15:0] alu_exp [8];

   initial begin
      errors = 0;
      checks = 0;
      alu_exp = '{16'h0000, 16'h00E0, 16'hE100, 16'hF0F0,
                  16'hFF00, 16'hFFF0, 16'h00F0, 16'hF0F1};
      reset = 1'b0;
      idle();
      cyc();
      cyc();

      // Held reset state
      check("rst_ra", bus.Ra_data, 16'h0000);
      check("rst_rb", bus.Rb_data, 16'h0000);
      check("rst_memq", bus.mem_q, 16'h0000);
      check("rst_zero", 16'(bus.zero), 16'd1);
      bus.ALU_s0 = 3'b111;
      #1;
      check("rst_alu_inc", bus.ALU_out, 16'h0001);
      check("rst_zero_inc", 16'(bus.zero), 16'd0);
      bus.ALU_s0 = 3'b000;
      reset = 1'b1;
      cyc();

      // Seed and add
      set_reg(4'd1, 16'h0005);
      set_reg(4'd2, 16'h0003);
      bus.RF_Ra_addr = 4'd1;
      bus.RF_Rb_addr = 4'd2;
      #1;
      check("seed_r1", bus.Ra_data, 16'h0005);
      check("seed_r2", bus.Rb_data, 16'h0003);
      bus.RF_W_addr = 4'd3;
      bus.ALU_s0    = 3'b001;
      bus.RF_W_en   = 1'b1;
      #1;
      check("add_alu", bus.ALU_out, 16'h0008);
      bus.RF_Ra_addr = 4'd3;
      #1;
      check("add_nobypass", bus.Ra_data, 16'h0000);
      bus.RF_Ra_addr = 4'd1;
      cyc();
      bus.RF_W_en    = 1'b0;
      bus.RF_Ra_addr = 4'd3;
      #1;
      check("add_r3", bus.Ra_data, 16'h0008);

      // Subtract with wrap into R0, then equal operands
      set_reg(4'd10, 16'h0002);
      set_reg(4'd9, 16'h0005);
      bus.RF_Ra_addr = 4'd10;
      bus.RF_Rb_addr = 4'd9;
      bus.ALU_s0     = 3'b010;
      bus.RF_W_addr  = 4'd0;
      bus.RF_W_en    = 1'b1;
      #1;
      check("sub_alu", bus.ALU_out, 16'hFFFD);
      check("sub_zero", 16'(bus.zero), 16'd0);
      cyc();
      bus.RF_W_en    = 1'b0;
      bus.RF_Ra_addr = 4'd0;
      #1;
      check("sub_r0", bus.Ra_data, 16'hFFFD);
      bus.RF_Ra_addr = 4'd9;
      #1;
      check("sub_eq_alu", bus.ALU_out, 16'h0000);
      check("sub_eq_zero", 16'(bus.zero), 16'd1);

      // All ALU functions
      set_reg(4'd5, 16'hF0F0);
      set_reg(4'd6, 16'h0FF0);
      bus.RF_Ra_addr = 4'd5;
      bus.RF_Rb_addr = 4'd6;
      for (int op = 0; op < 8; op++) begin
         bus.ALU_s0 = 3'(op);
         #1;
         check($sformatf("alu_op%0d", op), bus.ALU_out, alu_exp[op]);
      end
      bus.ALU_s0 = 3'b000;

      // STORE R4 to mem[0], read back, LOAD into R15
      set_reg(4'd4, 16'h1234);
      bus.RF_Ra_addr = 4'd4;
      bus.D_addr     = 8'h00;
      bus.D_Wr       = 1'b1;
      cyc();
      bus.D_Wr = 1'b0;
      cyc();
      check("store_memq", bus.mem_q, 16'h1234);
      bus.D_addr = 8'h10;
      cyc();
      bus.D_addr = 8'h00;
      cyc();
      bus.RF_s      = 1'b1;
      bus.RF_W_addr = 4'd15;
      bus.RF_W_en   = 1'b1;
      cyc();
      bus.RF_W_en    = 1'b0;
      bus.RF_s       = 1'b0;
      bus.RF_Ra_addr = 4'd15;
      #1;
      check("load_r15", bus.Ra_data, 16'h1234);

      // Read-during-write returns old data for one edge
      set_reg(4'd7, 16'h00AA);
      bus.RF_Ra_addr = 4'd7;
      bus.D_addr     = 8'h00;
      bus.D_Wr       = 1'b1;
      cyc();
      bus.D_Wr = 1'b0;
      check("rdw_old", bus.mem_q, 16'h1234);
      cyc();
      check("rdw_new", bus.mem_q, 16'h00AA);

      // Simultaneous memory and register write on the Ra source
      bus.RF_Ra_addr = 4'd4;
      bus.RF_W_addr  = 4'd4;
      bus.ALU_s0     = 3'b111;
      bus.RF_W_en    = 1'b1;
      bus.D_Wr       = 1'b1;
      bus.D_addr     = 8'h20;
      cyc();
      bus.RF_W_en = 1'b0;
      bus.D_Wr    = 1'b0;
      bus.ALU_s0  = 3'b000;
      check("simul_reg", bus.Ra_data, 16'h1235);
      cyc();
      check("simul_mem", bus.mem_q, 16'h1234);

      // Async reset mid-cycle during the second LOAD cycle; writes blocked while held
      bus.D_addr     = 8'h00;
      bus.RF_s       = 1'b1;
      bus.RF_W_addr  = 4'd15;
      bus.RF_W_en    = 1'b1;
      bus.RF_Ra_addr = 4'd1;
      bus.RF_Rb_addr = 4'd2;
      bus.ALU_s0     = 3'b000;
      #2;
      reset = 1'b0;
      #1;
      check("arst_ra", bus.Ra_data, 16'h0000);
      check("arst_rb", bus.Rb_data, 16'h0000);
      check("arst_memq", bus.mem_q, 16'h0000);
      check("arst_zero", 16'(bus.zero), 16'd1);
      bus.D_Wr = 1'b1;
      cyc();
      cyc();
      idle();
      reset = 1'b1;
      bus.RF_Ra_addr = 4'd15;
      bus.D_addr     = 8'h00;
      cyc();
      check("arst_r15", bus.Ra_data, 16'h0000);
      check("arst_mem_kept", bus.mem_q, 16'h00AA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/datapath_unit.md
# datapath_unit

Execution datapath driven by the processor control unit. It holds the 16-entry register file, the 256-word data memory, the write-back mux and the 8-function ALU. It executes the per-cycle control word (addresses, write enables, mux select, ALU select) that the control unit emits for NOOP/LOAD/STORE/ADD/SUB/HALT. The block is purely a responder: it never stalls the control unit and has no handshake back to it.

## Interface
- DATA_W, 16: data word width (register file, memory, ALU)
- RF_DEPTH, 16: register count; address width is 4
- MEM_DEPTH, 256: data memory words; address width is 8

- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all resettable state
- D_addr  in  8  data memory address
- D_Wr  in  1  data memory write enable
- RF_s  in  1  write-back select: 1 = memory read data, 0 = ALU result
- RF_W_en  in  1  register file write enable
- RF_W_addr  in  4  register file write address
- RF_Ra_addr  in  4  register file read port A address
- RF_Rb_addr  in  4  register file read port B address
- ALU_s0  in  3  ALU function select
- Ra_data  out  16  register file port A data, also ALU operand A and memory write data
- Rb_data  out  16  register file port B data, also ALU operand B
- ALU_out  out  16  ALU result
- mem_q  out  16  registered data memory read data
- zero  out  1  high when ALU_out == 0

## Operation
- Register file: 16×16 flops. Two combinational read ports and one synchronous write port. Write happens at the edge when RF_W_en=1: reg[RF_W_addr] <= wb_data. R0 is an ordinary writable register.
- Write-back: wb_data = RF_s ? mem_q : ALU_out.
- Data memory: 256×16, inferable as block RAM.
  - Write at the edge when D_Wr=1: mem[D_addr] <= Ra_data.
  - Read is synchronous: mem_q <= mem[D_addr] every edge, regardless of D_Wr.
  - Read-during-write to the same address returns the old data.
  - Contents are not reset and are undefined until written.
- ALU (combinational, unsigned, results mod 2^16, carry/borrow discarded):
  - 000: 0
  - 001: A+B
  - 010: A−B
  - 011: A
  - 100: A^B
  - 101: A|B
  - 110: A&B
  - 111: A+1
- Instruction mapping:
  - ADD/SUB: ALU_s0 = 001/010, RF_s = 0, RF_W_en = 1.
  - STORE: D_Wr = 1 with Ra = source register.
  - LOAD: two cycles (see Timing).
- RF_W_en and D_Wr may be asserted in the same cycle. Both writes take effect, and the memory write uses the pre-edge Ra_data.

## Timing
- Reset (reset=0, asynchronous):
  - All 16 registers clear to 0 and mem_q clears to 0 immediately, without waiting for a clock edge.
  - Resulting outputs: Ra_data=0, Rb_data=0, mem_q=0. ALU_out follows ALU_s0 (0 for every function except 111, which gives 1); zero=1 except when ALU_s0=111.
  - While reset is held, no register or memory write occurs.
- Reset release is sampled synchronously: the first write can occur on the first rising edge after reset goes high.
- Register write to read visibility: 1 edge. A write at edge N is visible on Ra_data/Rb_data right after edge N. Reading the same address in the write cycle returns the old value; there is no bypass.
- Memory read latency: 1 edge. D_addr presented in cycle N gives mem_q valid after edge N.
- LOAD protocol:
  - Cycle N: D_addr valid.
  - Cycle N+1: D_addr held, RF_s=1, RF_W_en=1. The register is written at edge N+1.
- STORE latency: written at the edge. A read of the same address in the next cycle yields the new data one edge later.
- Reset mid-LOAD: mem_q and the registers clear. After release, the pending write-back is lost, and the control unit restarts from its own reset.
- Out-of-range values cannot occur, since all address widths exactly cover the depths.

## Test plan
- Reset: assert reset=0 mid-cycle with registers non-zero -> Ra_data=Rb_data=mem_q=0 before the next edge; zero=1 with ALU_s0=000.
- Seed and add: seed R1=0x0005 and R2=0x0003 via ALU 111 chains or a STORE/LOAD pair, then Ra=1, Rb=2, W=3, ALU_s0=001, RF_W_en=1 -> R3=0x0008 after one edge.
- Subtract with wrap: R10=0x0002, R9=0x0005, ALU_s0=010, W=0 -> R0=0xFFFD, zero=0; with equal operands -> ALU_out=0, zero=1.
- STORE then LOAD: R4=0x1234, D_Wr=1, D_addr=0x00 -> next cycle mem_q=0x1234 (after a read edge). Then a LOAD to R15 over two cycles -> R15=0x1234. Read-during-write at the same address -> mem_q shows the old value for one edge.
- Simultaneous writes: D_Wr=1 and RF_W_en=1 with RF_W_addr equal to the Ra source -> memory receives the old Ra value and the register receives the ALU result.
- All ALU functions with A=0xF0F0, B=0x0FF0 -> 0x0000, 0x00E0, 0xE100, 0xF0F0, 0xFF00, 0xFFF0, 0x00F0, 0xF0F1.
